// File: rtl/tl_grant_ack_tracker.sv
// Two-entry sink ID allocator for TileLink Grant/GrantAck pairing.
// Optional per-entry GrantAck watchdog enabled by TL_GRANT_ACK_TIMEOUT_EN.
module tl_grant_ack_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       grant_req_valid,
    output logic       grant_req_ready,
    output logic       grant_req_sink,
    input  logic       e_valid,
    output logic       e_ready,
    input  logic       e_sink,
    output logic [1:0] busy,
    output logic       err_unexpected,
    output logic       timeout_err
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0] busy_q, busy_d;
    logic       err_q, err_d;
    logic       alloc_fire, e_fire, ack_hit;

    // Allocation decisions look only at registered state, so a same-cycle free never bypasses.
    assign grant_req_ready = ~(busy_q[0] & busy_q[1]);
    assign grant_req_sink  = busy_q[0];
    assign e_ready         = ~reset;
    assign busy            = busy_q;
    assign err_unexpected  = err_q;

    assign alloc_fire = grant_req_valid & grant_req_ready;
    assign e_fire     = e_valid & e_ready;
    assign ack_hit    = e_fire & busy_q[e_sink];

    // Alloc always targets a free entry and ack_hit a busy one, so they never collide.
    always_comb begin
        busy_d = busy_q;
        err_d  = e_fire & ~busy_q[e_sink];
        if (alloc_fire) busy_d[grant_req_sink] = 1'b1;
        if (ack_hit)    busy_d[e_sink]         = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

`ifdef TL_GRANT_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  tmo_q, tmo_d;

    // Counter holds cycles spent waiting since allocation, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        for (int n = 0; n < 2; n++) begin
            if (alloc_fire && (grant_req_sink == 1'(n))) begin
                cnt_d[n] = '0;
            end else if (busy_q[n] && (cnt_q[n] != CNT_MAX)) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
            if (busy_q[n] && (cnt_d[n] == CNT_LIM)) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_grant_ack_tracker.sv
// Scoreboard bench for tl_grant_ack_tracker: driver pushes model predictions, monitor pops and compares.
module tb_tl_grant_ack_tracker;

    localparam int unsigned T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       grant_req_valid = 1'b0;
    logic       grant_req_ready;
    logic       grant_req_sink;
    logic       e_valid = 1'b0;
    logic       e_ready;
    logic       e_sink = 1'b0;
    logic [1:0] busy;
    logic       err_unexpected;
    logic       timeout_err;

    tl_grant_ack_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .clock          (clock),
        .reset          (reset),
        .grant_req_valid(grant_req_valid),
        .grant_req_ready(grant_req_ready),
        .grant_req_sink (grant_req_sink),
        .e_valid        (e_valid),
        .e_ready        (e_ready),
        .e_sink         (e_sink),
        .busy           (busy),
        .err_unexpected (err_unexpected),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] busy;
        logic       ready;
        logic       sink;
        logic       err;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: set of outstanding sinks plus the edge index each was granted on.
    bit out_s[2];
    int alloc_edge[2];
    int edge_cnt = 0;
    bit tmo_m = 1'b0;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t model_view(bit err);
        exp_t e;
        e.busy  = {out_s[1], out_s[0]};
        e.ready = !(out_s[0] && out_s[1]);
        e.sink  = out_s[0] ? 1'b1 : 1'b0;
        e.err   = err;
        e.tmo   = tmo_m;
        return e;
    endfunction

    task automatic cycle(input bit gv, input bit ev, input bit es);
        bit ready, sink, alloc, free_hit, err;
        @(negedge clock);
        grant_req_valid = gv;
        e_valid         = ev;
        e_sink          = es;
        ready    = !(out_s[0] && out_s[1]);
        sink     = out_s[0] ? 1'b1 : 1'b0;
        alloc    = gv && ready;
        free_hit = ev && out_s[es];
        err      = ev && !out_s[es];
        edge_cnt++;
`ifdef TL_GRANT_ACK_TIMEOUT_EN
        for (int n = 0; n < 2; n++)
            if (out_s[n] && (edge_cnt - alloc_edge[n] >= int'(T))) tmo_m = 1'b1;
`endif
        if (free_hit) out_s[es] = 1'b0;
        if (alloc) begin
            out_s[sink]      = 1'b1;
            alloc_edge[sink] = edge_cnt;
        end
        exp_q.push_back(model_view(err));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        chk("drain", 8'(exp_q.size()), 8'd0);
    endtask

    // Reset asserted mid-cycle: state must clear with no clock edge.
    task automatic do_reset();
        drain();
        grant_req_valid = 1'b0;
        e_valid         = 1'b0;
        reset           = 1'b1;
        #1;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_err", 8'(err_unexpected), 8'd0);
        chk("rst_tmo", 8'(timeout_err), 8'd0);
        chk("rst_eready", 8'(e_ready), 8'd0);
        out_s[0] = 1'b0;
        out_s[1] = 1'b0;
        tmo_m    = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 8'(grant_req_ready), 8'd1);
        chk("post_rst_sink", 8'(grant_req_sink), 8'd0);
        chk("post_rst_eready", 8'(e_ready), 8'd1);
    endtask

    // Monitor: the DUT presents its state every cycle; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("busy", 8'(busy), 8'(e.busy));
                chk("ready", 8'(grant_req_ready), 8'(e.ready));
                chk("sink", 8'(grant_req_sink), 8'(e.sink));
                chk("err_unexpected", 8'(err_unexpected), 8'(e.err));
                chk("timeout_err", 8'(timeout_err), 8'(e.tmo));
                chk("e_ready", 8'(e_ready), 8'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #1;
        chk("init_busy", 8'(busy), 8'd0);
        chk("init_err", 8'(err_unexpected), 8'd0);
        chk("init_tmo", 8'(timeout_err), 8'd0);
        chk("init_eready", 8'(e_ready), 8'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("first_ready", 8'(grant_req_ready), 8'd1);
        chk("first_sink", 8'(grant_req_sink), 8'd0);

        // Fill both entries, then a request while full is ignored.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        // Full: free sink 1 with a concurrent request -> no bypass.
        cycle(1, 1, 1);
        // busy=01: alloc sink 1 and free sink 0 together -> 10.
        cycle(1, 1, 0);
        cycle(0, 1, 1);
        // Unexpected ack on an idle tracker, then the pulse must drop.
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Watchdog: no ack for T cycles, sticky afterwards.
        do_reset();
        cycle(1, 0, 0);
        for (int i = 0; i < int'(T) + 3; i++) cycle(0, 0, 0);
        // Ack arrives in time: no timeout.
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < int'(T) + 3; i++) cycle(0, 0, 0);

        // Reset with both entries outstanding drops them; later ack is unexpected.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        do_reset();
        cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ((i % 125) == 124) do_reset();
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
        end
        cycle(0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_grant_ack_tracker.md
TL_GRANT_ACK_TRACKER -- requirements
Module: tl_grant_ack_tracker

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, cycles an allocated sink may wait for GrantAck before timeout_err (range 1..255).
REQ-002 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: grant_req_valid  input  1  D-channel Grant issuer requests a sink ID.
REQ-005 SHALL have port: grant_req_ready  output  1  a sink ID is free.
REQ-006 SHALL have port: grant_req_sink  output  1  sink ID granted when valid&ready.
REQ-007 SHALL have port: e_valid  input  1  channel E GrantAck valid from the hart.
REQ-008 SHALL have port: e_ready  output  1  channel E GrantAck accepted.
REQ-009 SHALL have port: e_sink  input  1  sink ID being acknowledged.
REQ-010 SHALL have port: busy  output  2  per-sink outstanding flags, bit n = sink n.
REQ-011 SHALL have port: err_unexpected  output  1  one-cycle pulse, GrantAck for a non-outstanding sink.
REQ-012 SHALL have port: timeout_err  output  1  sticky, an outstanding sink exceeded TIMEOUT_CYCLES (macro-dependent).

Function
REQ-013 SHALL track two sink entries, each state FREE or WAIT_ACK, held in registered busy[1:0].
REQ-014 SHALL drive grant_req_ready = NOT(busy[0] AND busy[1]), combinational from registers only.
REQ-015 SHALL drive grant_req_sink = 0 if busy[0]==0, else 1; value meaningful only while grant_req_ready==1.
REQ-016 SHALL, on alloc fire (grant_req_valid & grant_req_ready), move entry grant_req_sink FREE->WAIT_ACK next edge.
REQ-017 SHALL drive e_ready = 1 constantly out of reset (E channel never back-pressured); e_ready = 0 while reset asserted.
REQ-018 SHALL, on E fire with busy[e_sink]==1, move entry e_sink WAIT_ACK->FREE next edge.
REQ-019 SHALL, on E fire with busy[e_sink]==0, leave busy unchanged and assert err_unexpected for exactly the following cycle.
REQ-020 SHALL permit alloc and free in the same cycle on different entries; both updates take effect on the same edge.
REQ-021 SHALL NOT bypass a same-cycle free into allocation: with busy==2'b11, a freed entry is allocatable no earlier than the next cycle.
REQ-022 SHALL have zero latency from busy update to grant_req_ready/grant_req_sink (one edge from fire to visible state).
REQ-023 SHALL ignore grant_req_valid while grant_req_ready==0 (no state change, no error).

Reset
REQ-024 SHALL, while reset is high, asynchronously force busy=2'b00, err_unexpected=0, timeout_err=0, all timeout counters=0.
REQ-025 SHALL, on reset mid-transaction, drop all outstanding entries; a later GrantAck for a dropped sink SHALL raise err_unexpected.
REQ-026 SHALL present grant_req_ready=1, grant_req_sink=0 in the first cycle after reset deassertion.

Configuration
REQ-027 SHALL compile the timeout watchdog only when macro TL_GRANT_ACK_TIMEOUT_EN is defined.
REQ-028 SHALL, with TL_GRANT_ACK_TIMEOUT_EN, keep an 8-bit counter per entry: cleared on alloc, incremented each cycle in WAIT_ACK, saturating.
REQ-029 SHALL, with TL_GRANT_ACK_TIMEOUT_EN, set timeout_err on the edge a counter reaches TIMEOUT_CYCLES while its entry is WAIT_ACK; cleared only by reset.
REQ-030 SHALL, without TL_GRANT_ACK_TIMEOUT_EN, tie timeout_err to 0 and instantiate no counters.
REQ-031 SHALL, in both builds, keep REQ-013..REQ-026 behaviour identical.

Verification
REQ-032 SHALL cover: reset release, grant_req_valid=1 two cycles -> sinks 0 then 1 allocated, busy=2'b11, grant_req_ready=0.
REQ-033 SHALL cover: busy=2'b11, e_valid=1 e_sink=1 with grant_req_valid=1 same cycle -> no alloc that cycle, next cycle busy=2'b01, grant_req_sink=1, ready=1.
REQ-034 SHALL cover: busy=2'b01, alloc and E fire e_sink=0 same cycle -> next cycle busy=2'b10.
REQ-035 SHALL cover: busy=2'b00, e_valid=1 e_sink=1 -> err_unexpected=1 for one cycle, busy stays 2'b00.
REQ-036 SHALL cover (macro defined, TIMEOUT_CYCLES=4): alloc sink 0, no E for 4 cycles -> timeout_err=1 and stays 1 until reset; with ack at cycle 3 -> timeout_err stays 0.
REQ-037 SHALL cover: reset asserted mid-cycle with busy=2'b11 -> busy=2'b00 immediately without clock edge; post-reset e_sink=0 ack -> err_unexpected pulse.
